// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction width, opcodes, NOP word and fetch state encoding
package cpu_pkg;
   localparam int INSTR_W = 16;
   localparam int OPC_W = 3;
   localparam logic [OPC_W-1:0] OP_LDD = 3'b001;
   localparam logic [OPC_W-1:0] OP_STD = 3'b010;
   localparam logic [OPC_W-1:0] OP_ADD = 3'b011;
   localparam logic [OPC_W-1:0] OP_NOT = 3'b100;
   localparam logic [OPC_W-1:0] OP_NOP = 3'b101;
   localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};
   typedef enum logic [1:0] {ISSUE, HOLD, DROP} fetch_state_e;
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction+PC holding register with load/unload/clear
module fetch_skid_buf #(
   parameter int PC_W = 10,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               unload,
   input  logic               clear,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= '0;
         pc <= '0;
      end else begin
         valid <= clear || unload ? 1'b0 : load ? 1'b1 : valid;
         if (load && !clear) begin
            instr <= in_instr;
            pc <= in_pc;
         end
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction fetch over req/ack and the IF/ID register feeding decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_squashed saturating counters.
module fetch_unit #(
   parameter int PC_W = 10,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               flush,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [2:0]         if_id_opcode,
   output logic [PC_W-1:0]    if_id_pc,
   output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        perf_fetched,
   output logic [15:0]        perf_squashed
`endif
);
   import cpu_pkg::*;
   localparam logic [INSTR_W-1:0] NOP = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};
   fetch_state_e state, state_nx;
   logic run, redirect, ack, take, load_mem, load_skid, skid_valid;
   logic [PC_W-1:0] pc, pc_nx, drop_addr, skid_pc;
   logic [INSTR_W-1:0] skid_instr, instr_nx;

   assign redirect = flush | branch_taken;
   // run keeps the request low until the first edge after reset release
   assign imem_req = run & (state != HOLD);
   assign imem_addr = state == DROP ? drop_addr : pc;
   assign ack = imem_req & imem_ack;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ISSUE;
      else state <= state_nx;

   always_comb
      state_nx = redirect ? (imem_req && !imem_ack ? DROP : ISSUE)
               : state == ISSUE ? (ack && stall ? HOLD : ISSUE)
               : state == HOLD ? (stall ? HOLD : ISSUE)
               : (ack ? ISSUE : DROP);

   always_comb begin
      take = !redirect && state == ISSUE && ack;
      load_mem = take && !stall;
      load_skid = !redirect && state == HOLD && !stall;
      pc_nx = redirect ? (branch_taken ? branch_target : pc) : take ? pc + PC_W'(1) : pc;
      instr_nx = redirect ? NOP : load_skid ? skid_instr : imem_rdata;
   end

   fetch_skid_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
      .clk(clk),
      .rst_n(rst_n),
      .load(take && stall),
      .unload(load_skid),
      .clear(redirect),
      .in_instr(imem_rdata),
      .in_pc(pc),
      .valid(skid_valid),
      .instr(skid_instr),
      .pc(skid_pc)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run <= 1'b0;
         pc <= RESET_PC;
         drop_addr <= RESET_PC;
         if_id_instr <= NOP;
         if_id_opcode <= OP_NOP;
         if_id_pc <= '0;
         if_id_valid <= 1'b0;
      end else begin
         run <= 1'b1;
         pc <= pc_nx;
         if (redirect) drop_addr <= imem_addr;
         if (redirect || load_mem || load_skid) begin
            if_id_instr <= instr_nx;
            if_id_opcode <= instr_nx[INSTR_W-1 -: 3];
         end
         if (load_mem || load_skid) if_id_pc <= load_mem ? pc : skid_pc;
         if_id_valid <= !redirect && (load_mem || load_skid || (stall && if_id_valid));
      end

`ifdef FETCH_PERF_CNT_EN
   logic [1:0] squash_n;
   always_comb
      squash_n = redirect ? 2'(ack) + 2'(if_id_valid) + 2'(skid_valid) : 2'(state == DROP && ack);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_squashed <= '0;
      end else begin
         perf_fetched <= sat_add16(perf_fetched, 2'(load_mem || load_skid));
         perf_squashed <= sat_add16(perf_squashed, squash_n);
      end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/delay/branch traffic checked against a stream model
module tb_fetch_unit;
   import cpu_pkg::*;
   localparam int PC_W = 10;
   logic clk = 1'b0, rst_n = 1'b0;
   logic stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
   logic [PC_W-1:0] branch_target = '0;
   logic imem_req, imem_ack, if_id_valid;
   logic [PC_W-1:0] imem_addr, if_id_pc;
   logic [15:0] imem_rdata, if_id_instr;
   logic [2:0] if_id_opcode;
   logic req2, valid2;
   logic [PC_W-1:0] addr2, pc2;
   logic [15:0] instr2;
   logic [2:0] opc2;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_f, perf_s, perf_f2, perf_s2;
`endif
   int n_chk = 0, n_fail = 0;
   logic rnd_mem = 1'b0;
   int slow_dly = 0, rnd_dly = 0, wcnt = 0, k, holds, consumed;
   logic [PC_W-1:0] slow_addr = '1, exp_pc, prev_addr;
   logic pend_nop, prev_pend;
   int seq[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] word(input logic [PC_W-1:0] a);
      return 16'h6000 | 16'(a);
   endfunction

   // memory: zero-wait by default, slow on slow_addr, random 0..2 waits in random mode
   assign imem_rdata = word(imem_addr);
   assign imem_ack = imem_req && wcnt >= (imem_addr == slow_addr ? slow_dly : rnd_mem ? rnd_dly : 0);
   always @(posedge clk)
      if (imem_req && imem_ack) begin
         wcnt <= 0;
         rnd_dly <= int'($urandom_range(0, 2));
      end else wcnt <= imem_req ? wcnt + 1 : 0;

   fetch_unit #(.PC_W(PC_W), .INSTR_W(16), .RESET_PC(10'h000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_f), .perf_squashed(perf_s)
`endif
   );

   fetch_unit #(.PC_W(PC_W), .INSTR_W(16), .RESET_PC(10'h3FF)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(req2), .imem_rdata(word(addr2)), .stall(1'b0), .flush(1'b0),
      .branch_taken(1'b0), .branch_target(10'h000),
      .if_id_instr(instr2), .if_id_opcode(opc2), .if_id_pc(pc2), .if_id_valid(valid2)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_f2), .perf_squashed(perf_s2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic do_reset();
      stall = 1'b0;
      flush = 1'b0;
      branch_taken = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      k = 0;
      while (!if_id_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(if_id_valid), 1);
   endtask

   initial begin
      // reset state and zero-wait streaming; wrap instance starts at 0x3FF
      do_reset();
      check("rst_valid", 32'(if_id_valid), 0);
      check("rst_instr", 32'(if_id_instr), 32'(NOP_WORD));
      check("rst_opcode", 32'(if_id_opcode), 32'(OP_NOP));
      check("rst_pc", 32'(if_id_pc), 0);
      check("rst_req", 32'(imem_req), 0);
      check("rst_addr", 32'(imem_addr), 0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf_f", 32'(perf_f), 0);
      check("rst_perf_s", 32'(perf_s), 0);
`endif
      wait_valid("t1_first_valid");
      for (int i = 0; i < 4; i++) begin
         check("t1_pc", 32'(if_id_pc), i);
         check("t1_valid", 32'(if_id_valid), 1);
         check("t1_opcode", 32'(if_id_opcode), 3);
         if (i == 0) begin
            check("wrap_pc0", 32'(pc2), 32'h3FF);
            check("wrap_instr0", 32'(instr2), 32'h63FF);
         end
         if (i == 1) begin
            check("wrap_pc1", 32'(pc2), 0);
            check("wrap_valid1", 32'(valid2), 1);
            check("wrap_opc1", 32'(opc2), 3);
         end
         @(negedge clk);
      end
`ifdef FETCH_PERF_CNT_EN
      check("t1_perf_f", 32'(perf_f), 5);
      check("wrap_perf_s", 32'(perf_s2), 0);
      check("wrap_perf_f", 32'(perf_f2 > 0), 1);
`endif

      // ack delayed 3 cycles on address 2
      do_reset();
      slow_addr = 10'd2;
      slow_dly = 3;
      seq.delete();
      holds = 0;
      repeat (14) begin
         @(negedge clk);
         if (if_id_valid) seq.push_back(int'(if_id_pc));
         if (imem_req && imem_addr == 10'd2 && !imem_ack) begin
            holds++;
            check("t2_hold_pc", 32'(if_id_pc), 1);
         end
      end
      check("t2_hold_cycles", holds, 3);
      for (int i = 0; i < 6; i++) check("t2_seq", i < seq.size() ? seq[i] : -1, i);
      slow_addr = '1;
      slow_dly = 0;

      // stall while pc=5 is acked, then a plain flush
      do_reset();
      k = 0;
      while (!(if_id_valid && if_id_pc == 10'd4) && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t3_reach_pc4", 32'(if_id_pc), 4);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_hold_pc", 32'(if_id_pc), 4);
         check("t3_hold_valid", 32'(if_id_valid), 1);
         check("t3_hold_req", 32'(imem_req), 0);
      end
      stall = 1'b0;
      @(negedge clk);
      check("t3_pc5", 32'(if_id_pc), 5);
      check("t3_pc5_instr", 32'(if_id_instr), 32'h6005);
      @(negedge clk);
      check("t3_pc6", 32'(if_id_pc), 6);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("t3_flush_valid", 32'(if_id_valid), 0);
      check("t3_flush_instr", 32'(if_id_instr), 32'(NOP_WORD));
      check("t3_flush_opc", 32'(if_id_opcode), 32'(OP_NOP));
`ifdef FETCH_PERF_CNT_EN
      check("t3_perf_s", 32'(perf_s), 2);
`endif
      @(negedge clk);
      check("t3_refetch_pc", 32'(if_id_pc), 7);
      check("t3_refetch_valid", 32'(if_id_valid), 1);

      // branch while pc=7 is outstanding
      do_reset();
      slow_addr = 10'd7;
      slow_dly = 4;
      k = 0;
      while (!(imem_req && imem_addr == 10'd7 && !imem_ack) && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t4_reach_pc7", 32'(imem_addr), 7);
      branch_taken = 1'b1;
      branch_target = 10'h3F0;
      @(negedge clk);
      branch_taken = 1'b0;
      check("t4_nop_valid", 32'(if_id_valid), 0);
      check("t4_nop_instr", 32'(if_id_instr), 32'(NOP_WORD));
      check("t4_drop_req", 32'(imem_req), 1);
      check("t4_drop_addr", 32'(imem_addr), 7);
      wait_valid("t4_after_branch_valid");
      check("t4_target_pc", 32'(if_id_pc), 32'h3F0);
      slow_addr = '1;
      slow_dly = 0;

      // asynchronous reset in the middle of HOLD
      do_reset();
      k = 0;
      while (!(if_id_valid && if_id_pc == 10'd2) && k < 40) begin
         @(negedge clk);
         k++;
      end
      stall = 1'b1;
      @(negedge clk);
      check("t6_in_hold_req", 32'(imem_req), 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(if_id_valid), 0);
      check("t6_async_instr", 32'(if_id_instr), 32'(NOP_WORD));
      check("t6_async_pc", 32'(if_id_pc), 0);
      check("t6_async_addr", 32'(imem_addr), 0);
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid("t6_restart_valid");
      check("t6_restart_pc", 32'(if_id_pc), 0);

      // randomized traffic: consumed stream must be sequential, restarting at each branch target
      do_reset();
      rnd_mem = 1'b1;
      exp_pc = '0;
      pend_nop = 1'b0;
      prev_pend = 1'b0;
      prev_addr = '0;
      consumed = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (pend_nop) begin
            check("rnd_nop_valid", 32'(if_id_valid), 0);
            check("rnd_nop_instr", 32'(if_id_instr), 32'(NOP_WORD));
         end
         if (prev_pend) check("rnd_addr_hold", 32'({imem_req, imem_addr}), 32'({1'b1, prev_addr}));
         prev_pend = imem_req && !imem_ack;
         prev_addr = imem_addr;
         stall = $urandom_range(0, 99) < 30;
         branch_taken = $urandom_range(0, 99) < 4;
         branch_target = PC_W'($urandom);
         pend_nop = branch_taken;
         if (branch_taken) exp_pc = branch_target;
         else if (if_id_valid && !stall) begin
            check("rnd_pc", 32'(if_id_pc), 32'(exp_pc));
            check("rnd_instr", 32'(if_id_instr), 32'(word(exp_pc)));
            check("rnd_opcode", 32'(if_id_opcode), 3);
            exp_pc++;
            consumed++;
         end
      end
      stall = 1'b0;
      branch_taken = 1'b0;
      check("rnd_progress", 32'(consumed > 200), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
